// File: rtl/lockstep_miter_chk.sv
// Lockstep gold-vs-gate comparator with per-bit care masks, a gold alignment delay,
// sticky per-channel flags and first-mismatch capture. Optional macro MITER_HALT_EN freezes comparing after the first mismatch.
module lockstep_miter_chk #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DELAY    = 0,
  parameter int CNT_W    = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          gold_vld_i,
  input  logic [CHANNELS*WIDTH-1:0]                     gold_i,
  input  logic                                          gate_vld_i,
  input  logic [CHANNELS*WIDTH-1:0]                     gate_i,
  input  logic [CHANNELS*WIDTH-1:0]                     care_i,
  input  logic                                          clear_i,
  output logic                                          fail_o,
  output logic                                          mismatch_o,
  output logic [CHANNELS-1:0]                           mismatch_ch_o,
  output logic                                          align_err_o,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] first_ch_o,
  output logic [CNT_W-1:0]                              first_cyc_o,
  output logic [WIDTH-1:0]                              first_gold_o,
  output logic [WIDTH-1:0]                              first_gate_o,
  output logic [CNT_W-1:0]                              cmp_cnt_o
);

  localparam int DW   = CHANNELS * WIDTH;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          gold_vld_d;
  logic [DW-1:0] gold_d;

  // Gold delay line; only rst flushes the valid bits, clear_i leaves samples in flight.
  generate
    if (DELAY == 0) begin : g_nodly
      assign gold_vld_d = gold_vld_i;
      assign gold_d     = gold_i;
    end else begin : g_dly
      logic [DELAY-1:0]    vld_sr_reg;
      logic [DELAY*DW-1:0] dat_sr_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr_reg <= '0;
        end else begin
          vld_sr_reg <= DELAY'({vld_sr_reg, gold_vld_i});
        end
      end

      always_ff @(posedge clk) begin
        dat_sr_reg <= (DELAY*DW)'({dat_sr_reg, gold_i});
      end

      assign gold_vld_d = vld_sr_reg[DELAY-1];
      assign gold_d     = dat_sr_reg[(DELAY-1)*DW +: DW];
    end
  endgenerate

  logic [CHANNELS-1:0] ch_mis;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ch_mis[gi] = |((gold_d[gi*WIDTH +: WIDTH] ^ gate_i[gi*WIDTH +: WIDTH])
                            & care_i[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  logic [CH_W-1:0]  first_idx;
  logic [WIDTH-1:0] sel_gold;
  logic [WIDTH-1:0] sel_gate;

  // Scan downwards so the lowest mismatching channel is the one left selected.
  always_comb begin
    first_idx = '0;
    sel_gold  = '0;
    sel_gate  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_mis[i]) begin
        first_idx = CH_W'(i);
        sel_gold  = gold_d[i*WIDTH +: WIDTH];
        sel_gate  = gate_i[i*WIDTH +: WIDTH];
      end
    end
  end

  logic                fail_reg;
  logic                mismatch_reg;
  logic [CHANNELS-1:0] mismatch_ch_reg;
  logic                align_err_reg;
  logic [CH_W-1:0]     first_ch_reg;
  logic [CNT_W-1:0]    first_cyc_reg;
  logic [WIDTH-1:0]    first_gold_reg;
  logic [WIDTH-1:0]    first_gate_reg;
  logic [CNT_W-1:0]    cmp_cnt_reg;
  logic [CNT_W-1:0]    cyc_reg;

  logic cmp_en;
`ifdef MITER_HALT_EN
  assign cmp_en = ~mismatch_reg;
`else
  assign cmp_en = 1'b1;
`endif

  logic cmp_fire;
  logic any_mis;
  assign cmp_fire = gold_vld_d & gate_vld_i & cmp_en;
  assign any_mis  = cmp_fire & (|ch_mis);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      fail_reg        <= 1'b0;
      mismatch_reg    <= 1'b0;
      mismatch_ch_reg <= '0;
      align_err_reg   <= 1'b0;
      first_ch_reg    <= '0;
      first_cyc_reg   <= '0;
      first_gold_reg  <= '0;
      first_gate_reg  <= '0;
      cmp_cnt_reg     <= '0;
      cyc_reg         <= '0;
    end else begin
      if (cyc_reg != CNT_MAX) begin
        cyc_reg <= cyc_reg + CNT_W'(1);
      end
      fail_reg <= any_mis;
      if (gold_vld_d != gate_vld_i) begin
        align_err_reg <= 1'b1;
      end
      if (cmp_fire && (cmp_cnt_reg != CNT_MAX)) begin
        cmp_cnt_reg <= cmp_cnt_reg + CNT_W'(1);
      end
      if (any_mis) begin
        mismatch_reg    <= 1'b1;
        mismatch_ch_reg <= mismatch_ch_reg | ch_mis;
        if (!mismatch_reg) begin
          first_ch_reg   <= first_idx;
          first_cyc_reg  <= cyc_reg;
          first_gold_reg <= sel_gold;
          first_gate_reg <= sel_gate;
        end
      end
    end
  end

  assign fail_o        = fail_reg;
  assign mismatch_o    = mismatch_reg;
  assign mismatch_ch_o = mismatch_ch_reg;
  assign align_err_o   = align_err_reg;
  assign first_ch_o    = first_ch_reg;
  assign first_cyc_o   = first_cyc_reg;
  assign first_gold_o  = first_gold_reg;
  assign first_gate_o  = first_gate_reg;
  assign cmp_cnt_o     = cmp_cnt_reg;

endmodule

// File: doc/lockstep_miter_chk.md
# lockstep_miter_chk

Parametrised, clocked lockstep comparator that checks gold (RTL) against gate (netlist) copies of the `jpeg_encoder` datapath registers, such as the `fdct_zigzag` DCT coefficient banks, during emulation and co-simulation runs. It is the run-time, multi-channel successor of the single-bit combinational equivalence miter. It adds:
- per-bit don't-care masking;
- a programmable gold-path alignment delay;
- valid-alignment checking;
- sticky per-channel failure flags;
- capture of the first mismatch.

## Interface
Parameters:
- `WIDTH`, 32, bits per channel
- `CHANNELS`, 4, number of compared channels (1..64)
- `DELAY`, 0, cycles of gold-path delay that match gate pipeline latency (0..15)
- `CNT_W`, 32, width of cycle and compare counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `gold_vld_i`  in  1  gold sample valid
- `gold_i`  in  CHANNELS*WIDTH  gold samples; channel c is at [c*WIDTH +: WIDTH]
- `gate_vld_i`  in  1  gate sample valid
- `gate_i`  in  CHANNELS*WIDTH  gate samples
- `care_i`  in  CHANNELS*WIDTH  per-bit compare mask (1 = compare); sampled together with gate_i
- `clear_i`  in  1  clears sticky flags, capture registers and counters
- `fail_o`  out  1  one-cycle pulse per mismatching compare
- `mismatch_o`  out  1  sticky: any mismatch since the last clear
- `mismatch_ch_o`  out  CHANNELS  sticky per-channel mismatch flags
- `align_err_o`  out  1  sticky: delayed gold valid differs from gate valid
- `first_ch_o`  out  max(1,$clog2(CHANNELS))  channel of the first mismatch
- `first_cyc_o`  out  CNT_W  cycle-counter value at the first mismatch
- `first_gold_o`, `first_gate_o`  out  WIDTH  data captured at the first mismatch
- `cmp_cnt_o`  out  CNT_W  number of compares performed (saturating)

## Operation
- The gold path (gold_vld_i, gold_i) passes through a DELAY-stage shift register that advances every cycle. DELAY=0 means no delay.
- Only `rst` clears the delay line; `clear_i` does not touch it.
- A compare is performed when the delayed gold valid and gate_vld_i are both 1.
- Channel c mismatches when ((gold_d[c] ^ gate[c]) & care[c]) != 0.
- A single-sided valid (delayed gold valid != gate_vld_i) sets `align_err_o`. No compare is performed that cycle and cmp_cnt_o does not increment.
- The compare result is registered:
  - fail_o pulses if any channel mismatches;
  - the matching mismatch_ch_o bits and mismatch_o are set and stay set.
- First-mismatch capture happens only while mismatch_o=0. It loads first_ch_o, first_cyc_o, first_gold_o and first_gate_o. If several channels mismatch in the same cycle, the lowest index wins.
- Cycle counter: increments every cycle after reset or clear. It is internal and visible only through first_cyc_o.
- Both the cycle counter and cmp_cnt_o saturate at 2^CNT_W-1 and never wrap.
- If clear_i is high in the same cycle as a compare, clear wins: that compare is discarded (no fail_o, no counting). Counters restart at 0 on the next cycle.
- Reset values: all outputs 0; delay line valids 0.
- Reset mid-run flushes in-flight gold samples. A gate sample arriving before DELAY fresh gold samples have propagated raises align_err_o.

## Timing
- Compare decision is made at cycle t from gate inputs at t and gold inputs at t-DELAY.
- fail_o, the sticky flags, capture registers and cmp_cnt_o update at t+1.
- first_cyc_o holds the counter value of cycle t, the compare cycle, not t+1.
- Throughput: one compare per cycle, with no back-pressure.
- clear_i takes effect at the next edge; its effect on outputs is visible at t+1.

## Configuration
- `MITER_HALT_EN` defined:
  - after the first mismatch, compares are suppressed: fail_o stays 0 and cmp_cnt_o and mismatch_ch_o freeze;
  - align_err_o still updates;
  - clear_i or rst re-arms the block.
- `MITER_HALT_EN` undefined: compares continue after a mismatch. fail_o pulses on every mismatch and mismatch_ch_o keeps accumulating.

## Test plan
- Parameters WIDTH=32, CHANNELS=4, DELAY=2, care all 1s. Drive identical streams with gold leading gate by 2 cycles for 100 compares.
  - Required: cmp_cnt_o=100, all flags 0.
- Same setup, but gate channel 2 = 0x0000_0010 vs gold 0x0000_0000 at cycle 37.
  - Required: fail_o pulse at cycle 38, mismatch_ch_o=4'b0100, first_ch_o=2, first_cyc_o=37, first_gate_o=0x10.
- Channels 1 and 3 mismatch in the same cycle.
  - Required: first_ch_o=1, mismatch_ch_o=4'b1010.
- Mismatching bit 4 with care bit 4 = 0.
  - Required: no fail_o; cmp_cnt_o still increments.
- gate_vld_i=1 while delayed gold valid=0.
  - Required: align_err_o=1, cmp_cnt_o unchanged.
- clear_i asserted in the same cycle as a mismatch.
  - Required: no fail_o, all flags 0, counters restart at 0.
- With MITER_HALT_EN defined, a second mismatch on channel 0 after a first on channel 2.
  - Required: mismatch_ch_o stays 4'b0100; cmp_cnt_o is frozen.
